// File: rtl/video_term_ctrl_if.sv
// ----------------------------------------------------------------------------
// video_term_ctrl_if
//   Groups the byte-source handshake and the video-memory character write
//   port of video_term_ctrl.
//   in_data/in_valid/in_ready : byte stream from the CPU/UART into the controller
//   vm_wr_en/addr/data        : registered single-cell write into video memory
//   modport slave  : the controller side
//   modport master : the byte source plus the video memory side
// ----------------------------------------------------------------------------
interface video_term_ctrl_if #(
  parameter int ADDR_W = 13
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              vm_wr_en;
  logic [ADDR_W-1:0] vm_wr_addr;
  logic [7:0]        vm_wr_data;

  modport slave (
    input  in_data, in_valid,
    output in_ready, vm_wr_en, vm_wr_addr, vm_wr_data
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, vm_wr_en, vm_wr_addr, vm_wr_data
  );
endinterface

// File: rtl/video_term_ctrl.sv
// ----------------------------------------------------------------------------
// video_term_ctrl
//   Character-stream controller for a COLS x ROWS text-mode video memory.
//   Accepts bytes over a valid/ready handshake, keeps a text cursor,
//   interprets CR/LF/BS/FF and drives the memory's only character write port.
//
//   Ports:
//     write_clk : the only clock (rising edge)
//     rst       : asynchronous active-high reset
//     bus       : video_term_ctrl_if.slave (byte handshake + memory write port)
//     cur_col   : cursor column 0..COLS-1
//     cur_row   : cursor row 0..ROWS-1
//     busy      : high while a clear sequence runs
//
//   Build option:
//     TERM_LINE_CLEAR_EN : when defined, every row advance (LF or last-column
//                          wrap) blanks the newly entered row before the next
//                          byte is accepted.
// ----------------------------------------------------------------------------
module video_term_ctrl #(
  parameter int         COLS     = 106,
  parameter int         ROWS     = 40,
  parameter int         ADDR_W   = 13,
  parameter logic [7:0] CLEAR_CH = 8'h20
) (
  input  logic              write_clk,
  input  logic              rst,
  video_term_ctrl_if.slave  bus,
  output logic [6:0]        cur_col,
  output logic [5:0]        cur_row,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CLR_SCREEN = 2'd1;
  localparam logic [1:0] ST_CLR_LINE   = 2'd2;

  localparam logic [6:0]        LAST_COL    = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW    = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);

`ifdef TERM_LINE_CLEAR_EN
  localparam bit LINE_CLEAR = 1'b1;
`else
  localparam bit LINE_CLEAR = 1'b0;
`endif

  logic [1:0]        state;
  logic [6:0]        col;
  logic [5:0]        row;
  logic [ADDR_W-1:0] cnt;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [7:0]        wr_data_p1;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Rows wrap to the top; there is no scrolling.
  function automatic logic [5:0] next_row(input logic [5:0] r);
    return (r == LAST_ROW) ? 6'd0 : r + 6'd1;
  endfunction

  logic accept;
  assign accept = bus.in_valid && (state == ST_IDLE);

  // Stage p0 -> p1: decode the accepted byte / step the clear counter and
  // register the resulting memory write.
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      cnt        <= '0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.in_data)
              8'h0D: col <= '0;
              8'h0A: begin
                row <= next_row(row);
                if (LINE_CLEAR) begin
                  state <= ST_CLR_LINE;
                  cnt   <= '0;
                end
              end
              8'h08: begin
                if (col != 7'd0) begin
                  col        <= col - 7'd1;
                  wr_en_p1   <= 1'b1;
                  wr_addr_p1 <= cell_addr(row, col - 7'd1);
                  wr_data_p1 <= CLEAR_CH;
                end
              end
              8'h0C: begin
                state <= ST_CLR_SCREEN;
                cnt   <= '0;
              end
              default: begin
                wr_en_p1   <= 1'b1;
                wr_addr_p1 <= cell_addr(row, col);
                wr_data_p1 <= bus.in_data;
                if (col == LAST_COL) begin
                  col <= '0;
                  row <= next_row(row);
                  if (LINE_CLEAR) begin
                    state <= ST_CLR_LINE;
                    cnt   <= '0;
                  end
                end else begin
                  col <= col + 7'd1;
                end
              end
            endcase
          end
        end
        ST_CLR_SCREEN: begin
          wr_en_p1   <= 1'b1;
          wr_addr_p1 <= cnt;
          wr_data_p1 <= CLEAR_CH;
          if (cnt == SCREEN_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLR_LINE: begin
          // row already points at the newly entered row.
          wr_en_p1   <= 1'b1;
          wr_addr_p1 <= cell_addr(row, 7'd0) + cnt;
          wr_data_p1 <= CLEAR_CH;
          if (cnt == LINE_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign bus.vm_wr_en   = wr_en_p1;
  assign bus.vm_wr_addr = wr_addr_p1;
  assign bus.vm_wr_data = wr_data_p1;
  assign cur_col        = col;
  assign cur_row        = row;

endmodule

// File: doc/video_term_ctrl.md
# video_term_ctrl

Character-stream controller that sequences writes into the text-mode video memory (106×40 cells, one 8-bit glyph code per cell). It accepts bytes over a valid/ready handshake, maintains a text cursor, interprets a small set of control codes, and runs multi-cycle clear sequences. It sits between the CPU/UART byte source and the video memory's character write port, and is the only writer of that port.

## Interface
- `COLS`, 106: characters per row.
- `ROWS`, 40: rows on screen.
- `ADDR_W`, 13: cell address width; `COLS*ROWS` must be ≤ 2^`ADDR_W`.
- `CLEAR_CH`, 8'h20: glyph code written by clears and backspace.
- `write_clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 8: byte to print or control code.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: controller can accept a byte; high only in IDLE.
- `vm_wr_en` out 1: registered write strobe to video memory.
- `vm_wr_addr` out `ADDR_W`: cell address, `row*COLS+col`.
- `vm_wr_data` out 8: glyph code to write.
- `cur_col` out 7: current cursor column, 0..`COLS`-1.
- `cur_row` out 6: current cursor row, 0..`ROWS`-1.
- `busy` out 1: high in CLR_SCREEN or CLR_LINE.

## Operation
- States: IDLE, CLR_SCREEN, CLR_LINE. `in_ready = (state==IDLE)`; `busy = !in_ready`.
- Byte accepted on an edge where `in_valid && in_ready`. Decode:
  - 0x0D (CR): col←0; no write.
  - 0x0A (LF): row advance; col unchanged; no write.
  - 0x08 (BS): if col>0, col←col-1 and write `CLEAR_CH` at the new position; at col 0, no-op.
  - 0x0C (FF): enter CLR_SCREEN, counter←0.
  - Any other value (including other codes <0x20 and 0x7F–0xFF): write the byte at (row,col), then col←col+1; at col=`COLS`-1, col←0 and row advance.
- Row advance: row←row+1; at row=`ROWS`-1, row←0 (wrap, no scroll).
- CLR_SCREEN: one write per cycle of `CLEAR_CH` at addresses 0..`COLS*ROWS`-1 (4240 writes), then cursor←(0,0) and state→IDLE.
- CLR_LINE (only with `TERM_LINE_CLEAR_EN`): one write per cycle of `CLEAR_CH` at `row*COLS+0` .. `row*COLS+COLS-1` of the row just entered, then IDLE. Cursor is already at the new row.
- Address arithmetic is unsigned at `ADDR_W` bits; row/col never exceed their limits, so no overflow.
- Reset mid-sequence aborts the clear immediately; memory contents already written are not restored.
- Reset values: state IDLE, col 0, row 0, counter 0, `vm_wr_en` 0, `vm_wr_addr` 0, `vm_wr_data` 0, `in_ready` 1, `busy` 0.

## Timing
- Accept at edge N → `vm_wr_en`/addr/data valid during cycle N+1 (one-cycle registered latency); `cur_col`/`cur_row` updated in cycle N+1.
- Back-to-back printables in IDLE: one accepted and one written per cycle; `in_ready` stays high.
- FF accepted at edge N: clear writes appear in cycles N+2..N+4241; `in_ready` high again in cycle N+4241. Cursor reads (0,0) from cycle N+4241.
- Line clear triggered at edge N: writes in cycles N+2..N+`COLS`+1; for a printable at the last column, its own write occupies cycle N+1. `in_ready` high in cycle N+`COLS`+1.
- `vm_wr_en` is never high for two different addresses in the same cycle; at most one write per cycle.
- `in_data` is sampled only on the accepting edge; it may change freely while `in_ready` is low.

## Configuration
- `TERM_LINE_CLEAR_EN` defined: every row advance (LF or last-column wrap) enters CLR_LINE for the new row.
- Undefined: row advance returns directly to IDLE; the new row keeps its old contents; CLR_LINE is unreachable; `in_ready` never drops except for FF.

## Test plan
- Reset, then send 'A' (0x41), 'B' (0x42) on consecutive cycles → writes addr 0 = 0x41, addr 1 = 0x42 on consecutive cycles; cursor (col 2, row 0).
- Send 106 printables starting at (0,0) → last write at addr 105; cursor (0,1); with `TERM_LINE_CLEAR_EN` 106 writes of 0x20 at addrs 106..211, `in_ready` low for exactly those cycles.
- Cursor at (0,39), send LF → cursor (0,0); with macro, clears addrs 0..105; without, no write and `in_ready` stays high.
- Cursor at (5,3): send BS → write 0x20 at addr 322, cursor (4,3); CR → cursor (0,3); BS at col 0 → no write.
- Send FF → exactly 4240 writes of 0x20 at addrs 0..4239 in order, `busy` high throughout; cursor (0,0); `in_valid` held high meanwhile is not accepted.
- Assert `rst` at clear write 2000 of FF → `vm_wr_en` 0 and `in_ready` 1 immediately (asynchronous); next 'Z' written at addr 0.
